// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game states, screen/net/ball geometry and score helper
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } game_state_e;

  // Screen and court geometry, shared with the ball block so landing and
  // collision math agree on the same numbers.
  localparam int VBUF_H    = 240;
  localparam int NET_POS_X = 158;
  localparam int NET_W     = 10;
  localparam int BALL_W    = 30;
  localparam int BALL_H    = 30;
  localparam int FLOOR_Y   = VBUF_H - 20;
  localparam int NET_CX    = NET_POS_X + NET_W / 2;

  // Increment that sticks at lim so a score can never wrap.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/game_ctrl_rise_detect.sv
// rtl/game_ctrl_rise_detect.sv - registered 1-bit rising edge detector
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle copy of d; reset to RESET_VAL so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) d_q <= RESET_VAL;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - rally/score sequencer: serve delay, landing detection, scoring, match end
module game_ctrl
  import game_pkg::*;
#(
  parameter int BALL_W_P  = BALL_W,
  parameter int BALL_H_P  = BALL_H,
  parameter int FLOOR_Y_P = FLOOR_Y,
  parameter int NET_CX_P  = NET_CX,
  parameter int DROP_WAIT = 100_000_000,
  parameter int WIN_SCORE = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  localparam int CNT_W = $clog2(DROP_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_WAIT - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  game_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             who_q, who_d;
  logic [3:0]       ps_q, ps_d;
  logic [3:0]       ns_q, ns_d;
  logic             pulse_q, pulse_d;
  logic             start_rise;
  logic             landed;
  logic             npc_side;
  logic [11:0]      ball_bottom;
  logic [11:0]      ball_cx;

  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start_btn),
    .rise  (start_rise)
  );

  // Ball geometry in 12-bit arithmetic, matching the ball block's own math.
  always_comb begin
    ball_bottom = Ball_Y + 12'(BALL_H_P);
    ball_cx     = Ball_X + 12'(BALL_W_P / 2);
    landed      = (ball_bottom >= 12'(FLOOR_Y_P));
    npc_side    = (ball_cx < 12'(NET_CX_P));
  end

  // State, serve counter, scores and strobe all update together on the clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      cnt_q   <= '0;
      who_q   <= 1'b0;
      ps_q    <= 4'd0;
      ns_q    <= 4'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      who_q   <= who_d;
      ps_q    <= ps_d;
      ns_q    <= ns_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic: serve delay in WAIT, one award per landing in PLAY, restart from END.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    who_d   = who_q;
    ps_d    = ps_q;
    ns_d    = ns_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_START: begin
        if (start_rise) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_PLAY;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_PLAY: begin
        if (landed) begin
          pulse_d = 1'b1;
          if (npc_side) begin
            ps_d    = sat_inc(ps_q, WIN);
            who_d   = 1'b0;
            state_d = (ps_d == WIN) ? ST_END : ST_WAIT;
          end else begin
            ns_d    = sat_inc(ns_q, WIN);
            who_d   = 1'b1;
            state_d = (ns_d == WIN) ? ST_END : ST_WAIT;
          end
        end
      end
      ST_END: begin
        if (start_rise) begin
          state_d = ST_START;
          ps_d    = 4'd0;
          ns_d    = 4'd0;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  assign Game_state   = state_q;
  assign who_win      = who_q;
  assign player_score = ps_q;
  assign npc_score    = ns_q;
  assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - table-driven scoreboard bench for game_ctrl
module tb_game_ctrl;

  logic        clk;
  logic        reset;
  logic        start_btn;
  logic [11:0] Ball_X;
  logic [11:0] Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  game_ctrl #(
    .DROP_WAIT (10),
    .WIN_SCORE (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .Game_state   (Game_state),
    .who_win      (who_win),
    .player_score (player_score),
    .npc_score    (npc_score),
    .point_pulse  (point_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        st;
    logic        tog;
    logic [11:0] x;
    logic [11:0] y;
    int          n;
    logic [1:0]  e_state;
    logic        e_who;
    logic [3:0]  e_ps;
    logic [3:0]  e_ns;
    logic        e_pulse;
  } vec_t;

  typedef struct {
    int         id;
    logic [1:0] state;
    logic       who;
    logic [3:0] ps;
    logic [3:0] ns;
    logic       pulse;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input int id, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL vec%0d %s: got %0d want %0d", id, name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic tog,
                     input int x, input int y, input int n,
                     input int es, input int ew, input int eps, input int ens, input int ep);
    vec_t v;
    v.rst = rst; v.st = st; v.tog = tog;
    v.x = 12'(x); v.y = 12'(y); v.n = n;
    v.e_state = 2'(es); v.e_who = 1'(ew);
    v.e_ps = 4'(eps); v.e_ns = 4'(ens); v.e_pulse = 1'(ep);
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
      // rst st tog  x    y    n   state who ps ns pulse
    // reset and first serve: WAIT lasts exactly 10 cycles
    add(1, 0, 0,  50,   0,  2,   0, 0, 0, 0, 0);
    add(0, 0, 0,  50,   0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  1,   1, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  9,   1, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  1,   2, 0, 0, 0, 0);
    // landing on the NPC side at the floor line: player scores
    add(0, 0, 0,  50, 190,  1,   1, 0, 1, 0, 1);
    add(0, 0, 0,  50,   0,  1,   1, 0, 1, 0, 0);
    add(0, 0, 0,  50,   0,  8,   1, 0, 1, 0, 0);
    add(0, 0, 0,  50,   0,  1,   2, 0, 1, 0, 0);
    // centre exactly on the net: player side, NPC scores
    add(0, 0, 0, 148, 195,  1,   1, 1, 1, 1, 1);
    add(0, 0, 0,  50,   0,  9,   1, 1, 1, 1, 0);
    add(0, 0, 0,  50,   0,  1,   2, 1, 1, 1, 0);
    // one pixel above the floor with start_btn toggling: nothing happens
    add(0, 0, 1,  50, 189, 20,   2, 1, 1, 1, 0);
    // centre one pixel left of the net: player scores
    add(0, 1, 0, 147, 190,  1,   1, 0, 2, 1, 1);
    add(0, 1, 0,  50,   0,  9,   1, 0, 2, 1, 0);
    add(0, 1, 0,  50,   0,  1,   2, 0, 2, 1, 0);
    // winning point with start held: END, scores frozen under a landed ball
    add(0, 1, 0,  50, 190,  1,   3, 0, 3, 1, 1);
    add(0, 1, 0,  50, 190,  3,   3, 0, 3, 1, 0);
    add(0, 0, 0,  50, 190,  1,   3, 0, 3, 1, 0);
    add(0, 1, 0,  50, 190,  1,   0, 0, 0, 0, 0);
    add(0, 0, 0,  50, 190,  3,   0, 0, 0, 0, 0);
    // reset mid-WAIT with start held
    add(0, 1, 0,  50,   0,  1,   1, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  5,   1, 0, 0, 0, 0);
    add(1, 1, 0,  50,   0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  3,   0, 0, 0, 0, 0);
    add(0, 0, 0,  50,   0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  1,   1, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  9,   1, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  1,   2, 0, 0, 0, 0);
    // centre one pixel right of the net: NPC scores, then reset mid-PLAY
    add(0, 1, 0, 149, 200,  1,   1, 1, 0, 1, 1);
    add(0, 1, 0,  50,   0,  9,   1, 1, 0, 1, 0);
    add(0, 1, 0,  50,   0,  1,   2, 1, 0, 1, 0);
    add(1, 1, 0,  50,   0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  3,   0, 0, 0, 0, 0);
    add(0, 0, 0,  50,   0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0,  50,   0,  1,   1, 0, 0, 0, 0);

    reset = 1'b1; start_btn = 1'b0; Ball_X = 12'd50; Ball_Y = 12'd0;

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      exp_t got;
      reset     = tbl[i].rst;
      start_btn = tbl[i].st;
      Ball_X    = tbl[i].x;
      Ball_Y    = tbl[i].y;
      e.id = i; e.state = tbl[i].e_state; e.who = tbl[i].e_who;
      e.ps = tbl[i].e_ps; e.ns = tbl[i].e_ns; e.pulse = tbl[i].e_pulse;
      sb.push_back(e);
      for (int c = 0; c < tbl[i].n; c++) begin
        if (tbl[i].tog && c > 0) start_btn = ~start_btn;
        @(posedge clk);
      end
      #1;
      got = sb.pop_front();
      check(got.id, "state", int'(Game_state),   int'(got.state));
      check(got.id, "who",   int'(who_win),      int'(got.who));
      check(got.id, "ps",    int'(player_score), int'(got.ps));
      check(got.id, "ns",    int'(npc_score),    int'(got.ns));
      check(got.id, "pulse", int'(point_pulse),  int'(got.pulse));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
